// File: rtl/compare_arbiter.sv
// -----------------------------------------------------------------------------
// compare_arbiter
//
// Shares a single combinational compare unit among N requesters. One requester
// is granted per transaction. Its operands are registered onto cmp_a/cmp_b, the
// comparator result is captured one cycle later, and a one-cycle ack is
// returned. A transaction takes three cycles: IDLE (grant), CMP, DONE (ack).
//
// Configuration macro: COMPARE_ARB_RR_EN
//   defined   : round-robin priority, with the search starting at a pointer
//               that advances past each served requester.
//   undefined : fixed priority, where the lowest index wins. No pointer is kept.
//
// Parameters
//   W : operand width (must match the compare unit)
//   N : number of requesters (2..8)
//
// Ports
//   clk        in   1     rising-edge clock
//   reset      in   1     synchronous, active-high reset
//   req        in   N     request lines, one per requester
//   a_in       in   N*W   packed A operands, requester i at [i*W +: W]
//   b_in       in   N*W   packed B operands, same packing
//   ack        out  N     one-hot, one-cycle completion pulse
//   res_out    out  1     captured compare result, valid with ack, then held
//   cmp_a      out  W     registered A operand to the compare unit
//   cmp_b      out  W     registered B operand to the compare unit
//   cmp_result in   1     result from the compare unit
//   busy       out  1     high while in CMP or DONE
// -----------------------------------------------------------------------------
module compare_arbiter #(
    parameter int W = 3,
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] a_in,
    input  logic [N*W-1:0] b_in,
    output logic [N-1:0]   ack,
    output logic           res_out,
    output logic [W-1:0]   cmp_a,
    output logic [W-1:0]   cmp_b,
    input  logic           cmp_result,
    output logic           busy
);

    localparam int IW = $clog2(N);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMP  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [IW-1:0]   r_gnt;
    logic [N-1:0]    r_ack;
    logic            r_res;
    logic [W-1:0]    r_cmp_a;
    logic [W-1:0]    r_cmp_b;
    logic            r_busy;
`ifdef COMPARE_ARB_RR_EN
    logic [IW-1:0]   r_ptr;
`endif

    logic [W-1:0]    w_a [N];
    logic [W-1:0]    w_b [N];
    logic [IW-1:0]   w_grant;
    logic [N-1:0]    w_gnt_onehot;

    // Unpack the flat operand buses so that the selected requester can be
    // indexed directly.
    for (genvar gi = 0; gi < N; gi++) begin : g_unpack
        assign w_a[gi] = a_in[gi*W +: W];
        assign w_b[gi] = b_in[gi*W +: W];
    end

    // Grant selection. The result is used only when req != 0, so the value it
    // takes with no request pending does not matter.
    always_comb begin
        // NOTE: every variable written here gets a default first, so a path
        // that never finds a set req bit cannot infer a latch.
        logic [IW:0]   v_sum;
        logic [IW-1:0] v_idx;
        logic          v_found;
        w_grant = '0;
        v_found = 1'b0;
        v_sum   = '0;
        v_idx   = '0;
        for (int k = 0; k < N; k++) begin
`ifdef COMPARE_ARB_RR_EN
            // Search upward from the pointer, wrapping modulo N. N may not be
            // a power of two, so a plain wrapping add is not enough.
            v_sum = {1'b0, r_ptr} + (IW+1)'(k);
            if (v_sum >= (IW+1)'(N)) begin
                v_sum = v_sum - (IW+1)'(N);
            end
            v_idx = v_sum[IW-1:0];
`else
            v_idx = IW'(k);
`endif
            if (!v_found && req[v_idx]) begin
                v_found = 1'b1;
                w_grant = v_idx;
            end
        end
    end

    assign w_gnt_onehot = N'(1) << r_gnt;

    // NOTE: all state here uses non-blocking assignments, so every register
    // sees the values from before the edge, whatever order the statements
    // are in.
    always_ff @(posedge clk) begin
        // NOTE: the reset is synchronous. It clears every register, including
        // a pending ack, on the next edge, whatever the current state.
        if (reset) begin
            r_state <= S_IDLE;
            r_gnt   <= '0;
            r_ack   <= '0;
            r_res   <= 1'b0;
            r_cmp_a <= '0;
            r_cmp_b <= '0;
            r_busy  <= 1'b0;
`ifdef COMPARE_ARB_RR_EN
            r_ptr   <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Operands are sampled only here. Later changes on
                    // a_in/b_in do not affect the transaction in flight.
                    if (req != '0) begin
                        r_gnt   <= w_grant;
                        r_cmp_a <= w_a[w_grant];
                        r_cmp_b <= w_b[w_grant];
                        r_busy  <= 1'b1;
                        r_state <= S_CMP;
                    end
                end
                S_CMP: begin
                    // The comparator has had a full cycle to settle on the
                    // registered operands. Capture the result and raise the
                    // ack for the DONE cycle, even if req has since dropped.
                    r_res   <= cmp_result;
                    r_ack   <= w_gnt_onehot;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_ack   <= '0;
                    r_busy  <= 1'b0;
`ifdef COMPARE_ARB_RR_EN
                    r_ptr   <= (r_gnt == IW'(N - 1)) ? '0 : r_gnt + 1'b1;
`endif
                    r_state <= S_IDLE;
                end
                default: begin
                    r_ack   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ack     = r_ack;
    assign res_out = r_res;
    assign cmp_a   = r_cmp_a;
    assign cmp_b   = r_cmp_b;
    assign busy    = r_busy;

endmodule

// File: tb/tb_compare_arbiter.sv
// -----------------------------------------------------------------------------
// tb_compare_arbiter
//
// Directed testbench for compare_arbiter with N=4 and W=3. The shared compare
// unit is modelled as result = (a >= b). Inputs are driven and outputs are
// sampled on the falling clock edge. The expected values are hand-computed
// for both the round-robin build (COMPARE_ARB_RR_EN) and the fixed-priority
// build.
// -----------------------------------------------------------------------------
module tb_compare_arbiter;

    localparam int W = 3;
    localparam int N = 4;

    logic           clk;
    logic           reset;
    logic [N-1:0]   req;
    logic [N*W-1:0] a_in;
    logic [N*W-1:0] b_in;
    logic [N-1:0]   ack;
    logic           res_out;
    logic [W-1:0]   cmp_a;
    logic [W-1:0]   cmp_b;
    logic           cmp_result;
    logic           busy;

    int n_tests;
    int n_fail;

    compare_arbiter #(.W(W), .N(N)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .a_in       (a_in),
        .b_in       (b_in),
        .ack        (ack),
        .res_out    (res_out),
        .cmp_a      (cmp_a),
        .cmp_b      (cmp_b),
        .cmp_result (cmp_result),
        .busy       (busy)
    );

    // Compare unit model.
    assign cmp_result = (cmp_a >= cmp_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        a_in[i*W +: W] = a;
        b_in[i*W +: W] = b;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_ack"},   32'(ack),     32'h0);
        check({tag, "_res"},   32'(res_out), 32'h0);
        check({tag, "_cmp_a"}, 32'(cmp_a),   32'h0);
        check({tag, "_cmp_b"}, 32'(cmp_b),   32'h0);
        check({tag, "_busy"},  32'(busy),    32'h0);
    endtask

    int          exp_g [5];
    logic        exp_r [4];
    int          tr;
    logic [N-1:0] exp_ack;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        req     = '0;
        a_in    = '0;
        b_in    = '0;

        // Reset state.
        do_reset();
        check_idle_zero("rst");

        // Single request from requester 1 with (5,5).
        set_ops(1, 3'd5, 3'd5);
        req = 4'b0010;
        step();
        check("t1_busy_cmp", 32'(busy),  32'h1);
        check("t1_cmp_a",    32'(cmp_a), 32'd5);
        check("t1_cmp_b",    32'(cmp_b), 32'd5);
        check("t1_ack_cmp",  32'(ack),   32'h0);
        step();
        check("t1_ack",      32'(ack),     32'h2);
        check("t1_res",      32'(res_out), 32'h1);
        check("t1_busy_done",32'(busy),    32'h1);
        req = '0;
        step();
        check("t1_ack_off",  32'(ack),     32'h0);
        check("t1_busy_off", 32'(busy),    32'h0);
        check("t1_res_hold", 32'(res_out), 32'h1);
        check("t1_a_hold",   32'(cmp_a),   32'd5);

        // All four requesting, distinct operands. Model results:
        // 0:(1,2)->0  1:(6,3)->1  2:(4,4)->1  3:(0,7)->0
        do_reset();
        set_ops(0, 3'd1, 3'd2);
        set_ops(1, 3'd6, 3'd3);
        set_ops(2, 3'd4, 3'd4);
        set_ops(3, 3'd0, 3'd7);
        exp_r = '{1'b0, 1'b1, 1'b1, 1'b0};
`ifdef COMPARE_ARB_RR_EN
        exp_g = '{0, 1, 2, 3, 0};
`else
        exp_g = '{0, 0, 0, 0, 0};
`endif
        req = 4'b1111;
        for (int c = 1; c <= 14; c++) begin
            step();
            if (c % 3 == 2) begin
                tr      = c / 3;
                exp_ack = 4'b0001 << exp_g[tr];
                check($sformatf("all_ack_c%0d", c), 32'(ack),     32'(exp_ack));
                check($sformatf("all_res_c%0d", c), 32'(res_out), 32'(exp_r[exp_g[tr]]));
            end else begin
                check($sformatf("all_ack_c%0d", c), 32'(ack), 32'h0);
            end
        end
        req = '0;
        step();
        check("all_busy_end", 32'(busy), 32'h0);
        check("all_ack_end",  32'(ack),  32'h0);

        // Operand change after grant: requester 2 with (3,6). a_in[2] becomes 7
        // during CMP. The result must still reflect (3,6), which is 0.
        set_ops(2, 3'd3, 3'd6);
        req = 4'b0100;
        step();
        set_ops(2, 3'd7, 3'd6);
        check("opchg_cmp_a", 32'(cmp_a), 32'd3);
        check("opchg_cmp_b", 32'(cmp_b), 32'd6);
        step();
        check("opchg_ack",   32'(ack),     32'h4);
        check("opchg_res",   32'(res_out), 32'h0);
        check("opchg_a_dn",  32'(cmp_a),   32'd3);
        req = '0;
        step();

        // Reset during CMP: the ack is suppressed and everything returns to zero.
        // The pointer, which would be 3 in a round-robin build, is cleared, so
        // req 1001 then grants requester 0.
        set_ops(2, 3'd2, 3'd1);
        req = 4'b0100;
        step();
        check("rcmp_busy", 32'(busy), 32'h1);
        reset = 1'b1;
        step();
        check_idle_zero("rcmp");
        reset = 1'b0;
        set_ops(0, 3'd5, 3'd2);
        set_ops(3, 3'd1, 3'd6);
        req = 4'b1001;
        step();
        check("rcmp_nx_cmp_a", 32'(cmp_a), 32'd5);
        check("rcmp_nx_cmp_b", 32'(cmp_b), 32'd2);
        step();
        check("rcmp_nx_ack", 32'(ack),     32'h1);
        check("rcmp_nx_res", 32'(res_out), 32'h1);
        req = '0;
        step();

        // Request dropped after the grant: the ack still pulses once.
        set_ops(3, 3'd2, 3'd2);
        req = 4'b1000;
        step();
        req = '0;
        check("drop_busy", 32'(busy), 32'h1);
        step();
        check("drop_ack", 32'(ack),     32'h8);
        check("drop_res", 32'(res_out), 32'h1);
        step();
        check("drop_ack_off",  32'(ack),  32'h0);
        check("drop_busy_off", 32'(busy), 32'h0);
        step();
        check("drop_idle_ack",  32'(ack),  32'h0);
        check("drop_idle_busy", 32'(busy), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
